ext_mem_arbiter: RTL and testbench
==================================

Name: ext_mem_arbiter

Overview:
Controller that shares the L2 cache native front-end between N L1 back-end masters (instruction and data caches) using a registered round-robin grant. It also sequences L2 invalidation: a request from L1 is held until the current transfer completes and the L2 write-through buffer is empty, then issued as a single-cycle pulse.
It sits in ext_mem between the L1 cache back-ends and the L2 cache instance.

Parameters:
N_MASTERS, 2, number of requesting masters (1..4); master 0 has first priority after reset.
ADDR_W, 24, native byte-address width (DCACHE_ADDR_W).
DATA_W, 32, native data width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
m_valid  in  N_MASTERS  per-master request valid; held high until the matching m_ready
m_addr  in  N_MASTERS*ADDR_W  per-master address; master i occupies slice i
m_wdata  in  N_MASTERS*DATA_W  per-master write data
m_wstrb  in  N_MASTERS*DATA_W/8  per-master byte strobes; all zero means read
m_rdata  out  N_MASTERS*DATA_W  per-master read data
m_ready  out  N_MASTERS  per-master completion, one cycle
s_valid  out  1  L2 request valid
s_addr  out  ADDR_W  L2 address
s_wdata  out  DATA_W  L2 write data
s_wstrb  out  DATA_W/8  L2 strobes
s_rdata  in  DATA_W  L2 read data
s_ready  in  1  L2 completion
inv_req  in  1  invalidate request pulse from L1 force_inv_out
wtb_empty  in  1  L2 write-through buffer empty
inv_out  out  1  one-cycle invalidate to L2 force_inv_in
busy  out  1  high when state is not IDLE or an invalidate is pending

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; rr_ptr=0; grant=0; inv_pending=0.
  - All outputs are 0: s_valid, s_addr, s_wdata, s_wstrb, m_ready, m_rdata, inv_out, busy.
- States: IDLE, BUSY, INV.
- inv_pending:
  - Set on any cycle with inv_req=1, in any state.
  - Cleared on the cycle state leaves INV.
  - If set and clear occur in the same cycle, set wins.
- IDLE transitions, in priority order:
  - inv_pending=1 and wtb_empty=1: go to INV.
  - inv_pending=1 and wtb_empty=0: stay in IDLE and issue no grant. New grants are blocked until the invalidate completes.
  - Otherwise, if any m_valid is set: pick the first set bit searching from rr_ptr upward with wrap-around. Register it as grant and go to BUSY.
  - Otherwise: stay in IDLE.
- INV:
  - inv_out=1 for exactly this cycle.
  - Next state is always IDLE.
  - s_valid=0 throughout.
- BUSY:
  - s_valid, s_addr, s_wdata and s_wstrb are driven combinationally from slice [grant].
  - m_ready[grant]=s_ready, and m_rdata slice [grant]=s_rdata.
  - All other m_ready bits and m_rdata slices are 0.
  - On s_ready=1: rr_ptr<=grant+1, wrapping to 0 at N_MASTERS; return to IDLE.
  - inv_req during BUSY only sets inv_pending. It never interrupts the transfer.
- Outside BUSY: s_valid=0, and s_addr, s_wdata, s_wstrb are 0.
- Latency: grant overhead is 1 cycle (IDLE to BUSY), so the earliest m_ready is cycle 2 after m_valid rises, with 1-cycle slave ready. Back-to-back requests incur one IDLE cycle between transfers.
- A master dropping m_valid in BUSY before ready is a protocol violation. s_valid follows the master; behaviour is undefined.
- Fairness: with all masters continuously requesting, grants rotate 0,1,..,N-1,0. No master waits more than N_MASTERS transfers.
- N_MASTERS=1: grant is always 0; rr_ptr stays 0.

Test Plan:
- Single master 1 read at addr 0x000100, L2 ready 3 cycles after s_valid, s_rdata=0xDEADBEEF -> s_valid is seen 1 cycle after m_valid; m_ready[1]=1 with m_rdata[1]=0xDEADBEEF; m_ready[0]=0; return to IDLE.
- Both masters valid continuously for 6 transfers, 1-cycle L2 -> grant order 0,1,0,1,0,1; one idle cycle between transfers.
- inv_req pulsed mid-BUSY (master 0 write, wstrb=0xF), wtb_empty=1 -> transfer completes normally; inv_out=1 for exactly 1 cycle on the cycle after return to IDLE; master 1's pending request is granted after INV.
- inv_req in IDLE with wtb_empty=0 for 5 cycles while master 0 is valid -> no grant and no inv_out during those cycles; inv_out pulses 1 cycle after wtb_empty rises; master 0 is granted afterwards.
- inv_req coincident with INV cycle -> inv_pending remains 1; a second inv_out pulse follows (IDLE then INV).
- rst asserted mid-BUSY -> all outputs are 0 immediately; after release, grant starts from master 0.

Source files
------------

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: shares the L2 native front-end between N L1 back-ends with a
// registered round-robin grant, and sequences L2 invalidation so it only fires
// between transfers once the L2 write-through buffer has drained.
module ext_mem_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0]     m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  input  logic                            inv_req,
  input  logic                            wtb_empty,
  output logic                            inv_out,
  output logic                            busy
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, INV} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic             inv_pending;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic             in_busy;

  // First requesting master at or after ptr, wrapping; MSB flags "found".
  function automatic logic [PTR_W:0] rr_pick(input logic [N_MASTERS-1:0] v,
                                             input logic [PTR_W-1:0]     ptr);
    logic [PTR_W:0] r;
    int             j;
    r = '0;
    for (int k = int'(N_MASTERS) - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= int'(N_MASTERS)) j = j - int'(N_MASTERS);
      if (v[j]) r = {1'b1, PTR_W'(j)};
    end
    return r;
  endfunction

  // Round-robin candidate for the next grant.
  always_comb begin
    {pick_found, pick_idx} = rr_pick(m_valid, rr_ptr);
  end

  // Arbitration / invalidate sequencing state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      inv_pending <= 1'b0;
    end else begin
      // A new request in the same cycle as the INV pulse stays pending.
      inv_pending <= inv_req | (inv_pending & (state != INV));
      case (state)
        IDLE: begin
          if (inv_pending) begin
            if (wtb_empty) state <= INV;
          end else if (pick_found) begin
            grant <= pick_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (s_ready) begin
            rr_ptr <= (grant == PTR_W'(N_MASTERS - 1)) ? '0 : PTR_W'(grant + 1'b1);
            state  <= IDLE;
          end
        end
        INV:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_busy = (state == BUSY);
  assign inv_out = (state == INV);
  assign busy    = (state != IDLE) | inv_pending;

  // Slave-side request muxed from the granted master while a transfer is open.
  always_comb begin
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (in_busy) begin
      s_valid = m_valid[grant];
      s_addr  = m_addr[grant*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[grant*DATA_W +: DATA_W];
      s_wstrb = m_wstrb[grant*STRB_W +: STRB_W];
    end
  end

  // Completion and read data routed back only to the granted master.
  always_comb begin
    m_ready = '0;
    m_rdata = '0;
    if (in_busy) begin
      m_ready[grant]                  = s_ready;
      m_rdata[grant*DATA_W +: DATA_W] = s_rdata;
    end
  end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter (2 masters, 24-bit address, 32-bit data).
`timescale 1ns/1ps
module tb_ext_mem_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N*DW-1:0] m_rdata;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic            inv_req;
  logic            wtb_empty;
  logic            inv_out;
  logic            busy;

  int checks = 0;
  int errors = 0;

  ext_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .inv_req(inv_req), .wtb_empty(wtb_empty), .inv_out(inv_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_valid = 2'b11; m_addr = {24'h0000AA, 24'h000055};
    m_wdata = '0; m_wstrb = '0; s_rdata = 32'h12345678; s_ready = 1'b1;
    inv_req = 1'b0; wtb_empty = 1'b1;
    tick(); tick();
    #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b want 0", s_valid); end
    checks++; if (s_addr !== 24'h0) begin errors++; $display("FAIL reset_s_addr: got %h want 0", s_addr); end
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL reset_m_ready: got %b want 00", m_ready); end
    checks++; if (m_rdata !== 64'h0) begin errors++; $display("FAIL reset_m_rdata: got %h want 0", m_rdata); end
    checks++; if (inv_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_inv_busy: got inv_out=%b busy=%b want 0 0", inv_out, busy); end
    m_valid = 2'b00; s_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    m_valid = 2'b10; m_addr = {24'h000100, 24'h000000}; m_wstrb = '0;
    #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL single_idle_s_valid: got %b want 0", s_valid); end
    tick();
    checks++; if (s_valid !== 1'b1 || s_addr !== 24'h000100) begin errors++; $display("FAIL single_grant: got s_valid=%b s_addr=%h want 1 000100", s_valid, s_addr); end
    checks++; if (s_wstrb !== 4'h0 || busy !== 1'b1) begin errors++; $display("FAIL single_rd_strb: got wstrb=%h busy=%b want 0 1", s_wstrb, busy); end
    tick();
    tick();
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL single_wait: got m_ready=%b want 00", m_ready); end
    tick();
    s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL single_ready: got %b want 10", m_ready); end
    checks++; if (m_rdata !== {32'hDEADBEEF, 32'h0}) begin errors++; $display("FAIL single_rdata: got %h want deadbeef00000000", m_rdata); end
    tick();
    s_ready = 1'b0; m_valid = 2'b00;
    #1;
    checks++; if (s_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_back_idle: got s_valid=%b busy=%b want 0 0", s_valid, busy); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    logic [AW-1:0] exp_addr;
    m_valid = 2'b11; m_addr = {24'h000020, 24'h000010}; s_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_rdy  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 24'h000010 : 24'h000020;
      s_rdata  = 32'hA0000000 + 32'(i);
      #1;
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rr_idle_gap_%0d: got s_valid=%b want 0", i, s_valid); end
      tick();
      checks++; if (m_ready !== exp_rdy || s_addr !== exp_addr) begin errors++; $display("FAIL rr_grant_%0d: got m_ready=%b s_addr=%h want %b %h", i, m_ready, s_addr, exp_rdy, exp_addr); end
      tick();
    end
    m_valid = 2'b00; s_ready = 1'b0;
    tick();
  endtask

  task automatic test_inv_mid_busy();
    m_valid = 2'b11; m_addr = {24'h000080, 24'h000040};
    m_wdata = {32'h0, 32'hCAFEF00D}; m_wstrb = {4'h0, 4'hF}; wtb_empty = 1'b1;
    tick();
    checks++; if (s_wstrb !== 4'hF || s_wdata !== 32'hCAFEF00D || s_addr !== 24'h000040) begin errors++; $display("FAIL invb_write: got wstrb=%h wdata=%h addr=%h want f cafef00d 000040", s_wstrb, s_wdata, s_addr); end
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0; s_ready = 1'b1;
    #1;
    checks++; if (inv_out !== 1'b0 || m_ready !== 2'b01) begin errors++; $display("FAIL invb_no_interrupt: got inv_out=%b m_ready=%b want 0 01", inv_out, m_ready); end
    tick();
    s_ready = 1'b0; m_valid = 2'b10; m_wstrb = '0;
    #1;
    checks++; if (inv_out !== 1'b0 || s_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL invb_idle: got inv_out=%b s_valid=%b busy=%b want 0 0 1", inv_out, s_valid, busy); end
    tick();
    checks++; if (inv_out !== 1'b1 || s_valid !== 1'b0) begin errors++; $display("FAIL invb_pulse: got inv_out=%b s_valid=%b want 1 0", inv_out, s_valid); end
    tick();
    checks++; if (inv_out !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL invb_pulse_end: got inv_out=%b s_valid=%b want 0 0", inv_out, s_valid); end
    tick();
    s_ready = 1'b1;
    #1;
    checks++; if (s_addr !== 24'h000080 || m_ready !== 2'b10) begin errors++; $display("FAIL invb_m1_after: got s_addr=%h m_ready=%b want 000080 10", s_addr, m_ready); end
    tick();
    s_ready = 1'b0; m_valid = 2'b00;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL invb_done: got busy=%b want 0", busy); end
    tick();
  endtask

  task automatic test_inv_wait_wtb();
    wtb_empty = 1'b0; inv_req = 1'b1;
    tick();
    inv_req = 1'b0; m_valid = 2'b01; m_addr = {24'h0, 24'h000200};
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (s_valid !== 1'b0 || inv_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL invw_blocked_%0d: got s_valid=%b inv_out=%b busy=%b want 0 0 1", i, s_valid, inv_out, busy); end
      tick();
    end
    wtb_empty = 1'b1;
    #1;
    checks++; if (inv_out !== 1'b0) begin errors++; $display("FAIL invw_rise: got inv_out=%b want 0", inv_out); end
    tick();
    checks++; if (inv_out !== 1'b1 || s_valid !== 1'b0) begin errors++; $display("FAIL invw_pulse: got inv_out=%b s_valid=%b want 1 0", inv_out, s_valid); end
    tick();
    checks++; if (inv_out !== 1'b0) begin errors++; $display("FAIL invw_pulse_end: got inv_out=%b want 0", inv_out); end
    tick();
    s_ready = 1'b1;
    #1;
    checks++; if (s_valid !== 1'b1 || s_addr !== 24'h000200 || m_ready !== 2'b01) begin errors++; $display("FAIL invw_grant: got s_valid=%b s_addr=%h m_ready=%b want 1 000200 01", s_valid, s_addr, m_ready); end
    tick();
    s_ready = 1'b0; m_valid = 2'b00;
    tick();
  endtask

  task automatic test_inv_during_inv();
    wtb_empty = 1'b1; inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    #1;
    checks++; if (inv_out !== 1'b0) begin errors++; $display("FAIL invi_idle1: got inv_out=%b want 0", inv_out); end
    tick();
    checks++; if (inv_out !== 1'b1) begin errors++; $display("FAIL invi_pulse1: got inv_out=%b want 1", inv_out); end
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    #1;
    checks++; if (inv_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL invi_still_pending: got inv_out=%b busy=%b want 0 1", inv_out, busy); end
    tick();
    checks++; if (inv_out !== 1'b1) begin errors++; $display("FAIL invi_pulse2: got inv_out=%b want 1", inv_out); end
    tick();
    checks++; if (inv_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL invi_cleared: got inv_out=%b busy=%b want 0 0", inv_out, busy); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    m_valid = 2'b01; m_addr = {24'h000B00, 24'h000A00};
    tick();
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; m_valid = 2'b11;
    tick();
    checks++; if (s_addr !== 24'h000B00) begin errors++; $display("FAIL rstb_pre_grant: got s_addr=%h want 000b00", s_addr); end
    s_ready = 1'b1; s_rdata = 32'h55AA55AA;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (s_valid !== 1'b0 || s_addr !== 24'h0 || m_ready !== 2'b00 || m_rdata !== 64'h0) begin errors++; $display("FAIL rstb_outputs: got s_valid=%b s_addr=%h m_ready=%b m_rdata=%h want all 0", s_valid, s_addr, m_ready, m_rdata); end
    checks++; if (busy !== 1'b0 || inv_out !== 1'b0) begin errors++; $display("FAIL rstb_busy: got busy=%b inv_out=%b want 0 0", busy, inv_out); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (s_valid !== 1'b1 || s_addr !== 24'h000A00 || m_ready !== 2'b01) begin errors++; $display("FAIL rstb_restart_m0: got s_valid=%b s_addr=%h m_ready=%b want 1 000a00 01", s_valid, s_addr, m_ready); end
    tick();
    s_ready = 1'b0; m_valid = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_inv_mid_busy();
    test_inv_wait_wtb();
    test_inv_during_inv();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
